// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient loader: default sizes and FSM state codes.
package fir_pkg;

  localparam int FIR_W1 = 9;
  localparam int FIR_M  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Host config, load control, sample stream and FIR-facing signals of the coefficient loader.
interface fir_coeff_loader_if
  import fir_pkg::*;
#(
  parameter int W1 = FIR_W1,
  parameter int AW = $clog2(FIR_M)
);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W1-1:0] cfg_data;
  logic          load_start;
  logic          load_busy;
  logic          load_done;
  logic          s_valid;
  logic [W1-1:0] s_data;
  logic          s_ready;
  logic [W1-1:0] fir_x;
  logic [W1-1:0] fir_c;
  logic          fir_x_load;

  // Host / source / FIR side
  modport master (
    output cfg_we, cfg_addr, cfg_data, load_start, s_valid, s_data,
    input  load_busy, load_done, s_ready, fir_x, fir_c, fir_x_load
  );

  // Loader side
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, load_start, s_valid, s_data,
    output load_busy, load_done, s_ready, fir_x, fir_c, fir_x_load
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// M x W1 coefficient register file with async clear, range/lock-gated writes
// and a write-through read port.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int W1 = FIR_W1,
  parameter int M  = FIR_M,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          lock,
  input  logic [AW-1:0] wr_addr,
  input  logic [W1-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W1-1:0] rd_data
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(M);

  logic [W1-1:0] mem_q [M];
  logic [W1-1:0] mem_d [M];
  logic          wr_en;

  assign wr_en = we && !lock && ({1'b0, wr_addr} < DEPTH);

  // Next bank contents; reading mem_d gives same-cycle write-through
  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == AW'(i))) mem_d[i] = wr_data;
    end
  end

  // Read mux over the post-write view
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (rd_addr == AW'(i)) rd_data = mem_d[i];
    end
  end

  // Bank storage, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < M; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < M; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Shifts a host-written coefficient bank into the FIR (x_load=0), then forwards
// the upstream sample stream as FIR x (x_load=1). All outputs are registered.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int W1 = FIR_W1,
  parameter int M  = FIR_M,
  parameter int AW = $clog2(M)
) (
  input logic                clk,
  input logic                rst,
  fir_coeff_loader_if.slave  bus
);

  localparam logic [AW-1:0] K_LAST = AW'(M - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [W1-1:0] fir_c_q, fir_c_d;
  logic [W1-1:0] fir_x_q, fir_x_d;
  logic          fir_x_load_q, fir_x_load_d;
  logic          load_busy_q, load_busy_d;
  logic          load_done_q, load_done_d;
  logic          s_ready_q, s_ready_d;
  logic          lock;
  logic [AW-1:0] rd_addr;
  logic [W1-1:0] rd_data;

  assign lock = (state_q == ST_LOAD);

  // fir_c is registered one cycle ahead: the start edge fetches bank[0]
  // (with write-through), each LOAD edge fetches the entry after k.
  assign rd_addr = lock ? (k_q + AW'(1)) : '0;

  fir_coeff_bank #(
    .W1 (W1),
    .M  (M),
    .AW (AW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.cfg_we),
    .lock    (lock),
    .wr_addr (bus.cfg_addr),
    .wr_data (bus.cfg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // FSM, load counter and next values of all output registers
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    fir_c_d      = '0;
    fir_x_d      = '0;
    fir_x_load_d = 1'b1;
    load_busy_d  = 1'b0;
    load_done_d  = 1'b0;
    s_ready_d    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (k_q == K_LAST) begin
          state_d     = ST_RUN;
          k_d         = '0;
          load_done_d = 1'b1;
          s_ready_d   = 1'b1;
        end else begin
          k_d          = k_q + AW'(1);
          fir_c_d      = rd_data;
          fir_x_load_d = 1'b0;
          load_busy_d  = 1'b1;
        end
      end
      default: begin
        if (bus.load_start) begin
          state_d      = ST_LOAD;
          k_d          = '0;
          fir_c_d      = rd_data;
          fir_x_load_d = 1'b0;
          load_busy_d  = 1'b1;
        end else if (state_q == ST_RUN) begin
          s_ready_d = 1'b1;
          fir_x_d   = bus.s_valid ? bus.s_data : '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      fir_c_q      <= '0;
      fir_x_q      <= '0;
      fir_x_load_q <= 1'b1;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      s_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      fir_c_q      <= fir_c_d;
      fir_x_q      <= fir_x_d;
      fir_x_load_q <= fir_x_load_d;
      load_busy_q  <= load_busy_d;
      load_done_q  <= load_done_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign bus.fir_c      = fir_c_q;
  assign bus.fir_x      = fir_x_q;
  assign bus.fir_x_load = fir_x_load_q;
  assign bus.load_busy  = load_busy_q;
  assign bus.load_done  = load_done_q;
  assign bus.s_ready    = s_ready_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor compares them and tracks FIR taps.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int W1 = FIR_W1;
  localparam int M  = FIR_M;
  localparam int AW = $clog2(M);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fir_coeff_loader_if #(.W1(W1), .AW(AW)) bus ();

  fir_coeff_loader #(.W1(W1), .M(M), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle stamp used to match predictions with the monitor's sample point
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          xl;
    logic [W1-1:0] c;
    logic [W1-1:0] x;
    logic          busy;
    logic          done;
    logic          rdy;
  } exp_t;

  exp_t          sb[$];
  exp_t          pend[$];
  logic [W1-1:0] bank   [M];
  logic [W1-1:0] loaded [M];
  logic [W1-1:0] taps   [M];
  bit            running;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t rec(input logic xl, input logic [W1-1:0] c, input logic [W1-1:0] x,
                               input logic busy, input logic done, input logic rdy);
    exp_t e;
    e.cyc = 0; e.xl = xl; e.c = c; e.x = x; e.busy = busy; e.done = done; e.rdy = rdy;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < M; i++) bank[i] = '0;
    pend.delete();
    running = 1'b0;
  endtask

  // Predict the outputs after the coming edge from current inputs, then advance one cycle
  task automatic step();
    exp_t e;
    if (rst) begin
      model_reset();
      e = rec(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    end else if (pend.size() > 0) begin
      e = pend.pop_front();
    end else begin
      if (bus.cfg_we && int'(bus.cfg_addr) < M) bank[bus.cfg_addr] = bus.cfg_data;
      if (bus.load_start) begin
        for (int j = 0; j < M; j++) begin
          loaded[j] = bank[j];
          pend.push_back(rec(1'b0, bank[j], '0, 1'b1, 1'b0, 1'b0));
        end
        pend.push_back(rec(1'b1, '0, '0, 1'b0, 1'b1, 1'b1));
        running = 1'b1;
        e = pend.pop_front();
      end else if (running) begin
        e = rec(1'b1, '0, bus.s_valid ? bus.s_data : '0, 1'b0, 1'b0, 1'b1);
      end else begin
        e = rec(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
      end
    end
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input int addr, input int data, input bit ls,
                       input bit sv, input int sd);
    bus.cfg_we     = we;
    bus.cfg_addr   = AW'(addr);
    bus.cfg_data   = W1'(data);
    bus.load_start = ls;
    bus.s_valid    = sv;
    bus.s_data     = W1'(sd);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: compare every predicted cycle; model the FIR tap chain to check final taps
  always @(negedge clk) begin
    if (bus.fir_x_load === 1'b0) begin
      for (int i = 0; i < M - 1; i++) taps[i] <= taps[i + 1];
      taps[M - 1] <= bus.fir_c;
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("fir_x_load", 32'(bus.fir_x_load), 32'(e.xl));
      chk("fir_c",      32'(bus.fir_c),      32'(e.c));
      chk("fir_x",      32'(bus.fir_x),      32'(e.x));
      chk("load_busy",  32'(bus.load_busy),  32'(e.busy));
      chk("load_done",  32'(bus.load_done),  32'(e.done));
      chk("s_ready",    32'(bus.s_ready),    32'(e.rdy));
      if (e.done) begin
        for (int i = 0; i < M; i++) chk("fir_tap", 32'(taps[i]), 32'(loaded[i]));
      end
    end
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.load_start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    model_reset();

    // Reset, then quiet idle
    step();
    step();
    rst = 1'b0;
    idle(10);

    // Program {3, -2, 5, 7} and load
    drive(1'b1, 0, 3, 1'b0, 1'b0, 0);
    drive(1'b1, 1, 9'h1FE, 1'b0, 1'b0, 0);
    drive(1'b1, 2, 5, 1'b0, 1'b0, 0);
    drive(1'b1, 3, 7, 1'b0, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0);
    idle(M + 2);

    // Impulse and gapped stream in RUN
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 0, 1'b0, 1'b1, 0);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 10);
    drive(1'b0, 0, 0, 1'b0, 1'b0, int'($urandom_range(0, 511)));
    drive(1'b0, 0, 0, 1'b0, 1'b1, 20);
    idle(2);

    // Write-through on the start cycle
    drive(1'b1, 2, 9, 1'b1, 1'b0, 0);
    idle(M + 2);

    // Write and restart request during LOAD are ignored
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0);
    drive(1'b1, 0, 100, 1'b0, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0);
    idle(M + 2);

    // Reset while showing LOAD cycle 2
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0);
    idle(2);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_fir_x_load", 32'(bus.fir_x_load), 32'd1);
    chk("rst_fir_c",      32'(bus.fir_c),      32'd0);
    chk("rst_load_busy",  32'(bus.load_busy),  32'd0);
    chk("rst_load_done",  32'(bus.load_done),  32'd0);
    step();
    rst = 1'b0;
    idle(2);
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0);
    idle(M + 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, int'($urandom_range(0, M - 1)), int'($urandom),
            ($urandom % 20) == 0, $urandom % 2 == 1, int'($urandom));
    end
    idle(M + 2);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
